// File: rtl/div_issue_unit.sv
// Divider issue front end: an in-order instruction queue with a register
// status table that renames destinations to divider tags and snoops the CDB.
module div_issue_unit #(
    parameter  int DEPTH = 4,
    parameter  int NREG  = 8,
    localparam int RW    = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_valid,
    input  logic [RW-1:0] inst_rd,
    input  logic [RW-1:0] inst_rs1,
    input  logic [RW-1:0] inst_rs2,
    output logic          inst_ready,
    input  logic          all_busy,
    input  logic [7:0]    alloc_tag,
    output logic          issue,
    output logic [7:0]    q1_out,
    output logic [7:0]    q2_out,
    output logic [31:0]   v1_out,
    output logic [31:0]   v2_out,
    input  logic [40:0]   cdb,
    input  logic [RW-1:0] dbg_idx,
    output logic [31:0]   dbg_value,
    output logic [7:0]    dbg_tag
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
    } entry_t;

    logic [31:0]   val_q [NREG];
    logic [31:0]   val_d [NREG];
    logic [7:0]    tag_q [NREG];
    logic [7:0]    tag_d [NREG];
    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          cdb_vld;
    logic [7:0]    cdb_tag;
    logic [31:0]   cdb_val;
    entry_t        head;
    logic          empty;
    logic          push;
    logic          pop;

    assign cdb_vld    = cdb[40];
    assign cdb_tag    = cdb[39:32];
    assign cdb_val    = cdb[31:0];
    assign head       = fifo_q[rd_ptr_q];
    assign empty      = (count_q == '0);
    assign inst_ready = rst || (count_q < CW'(DEPTH));
    assign issue      = !rst && !empty && !all_busy;
    assign push       = inst_valid && inst_ready && !rst;
    assign pop        = issue;
    assign dbg_value  = val_q[dbg_idx];
    assign dbg_tag    = tag_q[dbg_idx];

    // A pending source whose tag is on the CDB right now is forwarded.
    function automatic logic [39:0] read_src(input logic [RW-1:0] idx);
        logic [39:0] r;
        if (tag_q[idx] == 8'h00) begin
            r = {8'h00, val_q[idx]};
        end else if (cdb_vld && cdb_tag == tag_q[idx]) begin
            r = {8'h00, cdb_val};
        end else begin
            r = {tag_q[idx], 32'h0};
        end
        return r;
    endfunction

    always_comb begin
        {q1_out, v1_out} = 40'h0;
        {q2_out, v2_out} = 40'h0;
        if (!rst && !empty) begin
            {q1_out, v1_out} = read_src(head.rs1);
            {q2_out, v2_out} = read_src(head.rs2);
        end
    end

    always_comb begin
        val_d    = val_q;
        tag_d    = tag_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (cdb_vld && cdb_tag != 8'h00) begin
            for (int i = 1; i < NREG; i++) begin
                if (tag_q[i] == cdb_tag) begin
                    val_d[i] = cdb_val;
                    tag_d[i] = 8'h00;
                end
            end
        end

        // Rename after capture so a same-edge rename keeps the new tag.
        if (pop && head.rd != '0) begin
            tag_d[head.rd] = alloc_tag;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = {inst_rd, inst_rs1, inst_rs2};
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= 32'(i);
                tag_q[i] <= 8'h00;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            val_q    <= val_d;
            tag_q    <= tag_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_div_issue_unit.sv
// Scoreboard bench for div_issue_unit: stimulus queues expected issue
// operands and status probes; a negedge monitor compares them.
module tb_div_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [2:0]  inst_rd, inst_rs1, inst_rs2;
    logic        inst_ready;
    logic        all_busy;
    logic [7:0]  alloc_tag;
    logic        issue;
    logic [7:0]  q1_out, q2_out;
    logic [31:0] v1_out, v2_out;
    logic [40:0] cdb;
    logic [2:0]  dbg_idx;
    logic [31:0] dbg_value;
    logic [7:0]  dbg_tag;

    div_issue_unit #(.DEPTH(4), .NREG(8)) dut (
        .clk(clk), .rst(rst),
        .inst_valid(inst_valid), .inst_rd(inst_rd),
        .inst_rs1(inst_rs1), .inst_rs2(inst_rs2),
        .inst_ready(inst_ready), .all_busy(all_busy),
        .alloc_tag(alloc_tag), .issue(issue),
        .q1_out(q1_out), .q2_out(q2_out),
        .v1_out(v1_out), .v2_out(v2_out),
        .cdb(cdb), .dbg_idx(dbg_idx),
        .dbg_value(dbg_value), .dbg_tag(dbg_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  q1;
        logic [31:0] v1;
        logic [7:0]  q2;
        logic [31:0] v2;
    } exp_t;

    typedef struct {
        int          kind;
        logic [2:0]  idx;
        logic [31:0] val;
        logic [7:0]  tag;
        logic        iss;
        logic        rdy;
        logic        zops;
    } probe_t;

    exp_t   exp_q[$];
    probe_t probe_q[$];
    int     checks = 0;
    int     errors = 0;

    always @(negedge clk) begin
        exp_t   e;
        probe_t p;
        if (issue === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue got issue=1 want no issue");
            end else begin
                e = exp_q.pop_front();
                if ({q1_out, v1_out, q2_out, v2_out} !== {e.q1, e.v1, e.q2, e.v2}) begin
                    errors++;
                    $display("FAIL issue_ops got q1=%h v1=%0d q2=%h v2=%0d want q1=%h v1=%0d q2=%h v2=%0d",
                             q1_out, v1_out, q2_out, v2_out, e.q1, e.v1, e.q2, e.v2);
                end
            end
        end
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            checks++;
            case (p.kind)
                0: begin
                    dbg_idx = p.idx;
                    #1;
                    if (dbg_value !== p.val || dbg_tag !== p.tag) begin
                        errors++;
                        $display("FAIL dbg_r%0d got val=%0d tag=%h want val=%0d tag=%h",
                                 p.idx, dbg_value, dbg_tag, p.val, p.tag);
                    end
                end
                1: begin
                    if (issue !== p.iss || inst_ready !== p.rdy ||
                        (p.zops && {q1_out, q2_out, v1_out, v2_out} !== 80'h0)) begin
                        errors++;
                        $display("FAIL ctrl got issue=%b ready=%b q1=%h q2=%h v1=%0d v2=%0d want issue=%b ready=%b zero_ops=%b",
                                 issue, inst_ready, q1_out, q2_out, v1_out, v2_out, p.iss, p.rdy, p.zops);
                    end
                end
                default: begin
                    if (exp_q.size() != 0) begin
                        errors++;
                        $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
                    end
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        inst_valid = 1'b1;
        inst_rd    = rd;
        inst_rs1   = rs1;
        inst_rs2   = rs2;
    endtask

    function automatic void expect_iss(input logic [7:0] q1, input logic [31:0] v1,
                                       input logic [7:0] q2, input logic [31:0] v2);
        exp_t e;
        e.q1 = q1; e.v1 = v1; e.q2 = q2; e.v2 = v2;
        exp_q.push_back(e);
    endfunction

    function automatic void probe_dbg(input logic [2:0] idx, input logic [31:0] val,
                                      input logic [7:0] tag);
        probe_t p;
        p = '{kind: 0, idx: idx, val: val, tag: tag, iss: 1'b0, rdy: 1'b0, zops: 1'b0};
        probe_q.push_back(p);
    endfunction

    function automatic void probe_ctrl(input logic iss, input logic rdy, input logic zops);
        probe_t p;
        p = '{kind: 1, idx: 3'd0, val: 32'd0, tag: 8'd0, iss: iss, rdy: rdy, zops: zops};
        probe_q.push_back(p);
    endfunction

    function automatic void probe_sb();
        probe_t p;
        p = '{kind: 2, idx: 3'd0, val: 32'd0, tag: 8'd0, iss: 1'b0, rdy: 1'b0, zops: 1'b0};
        probe_q.push_back(p);
    endfunction

    logic [2:0] fill_rd  [5] = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    logic [2:0] fill_rs1 [5] = '{3'd1, 3'd3, 3'd6, 3'd1, 3'd0};
    logic [2:0] fill_rs2 [5] = '{3'd2, 3'd4, 3'd5, 3'd7, 3'd0};

    initial begin
        rst = 1'b1; inst_valid = 1'b0;
        inst_rd = 3'd0; inst_rs1 = 3'd0; inst_rs2 = 3'd0;
        all_busy = 1'b0; alloc_tag = 8'h00; cdb = 41'h0; dbg_idx = 3'd0;

        step(); step();
        probe_ctrl(1'b0, 1'b1, 1'b1);
        step();
        rst = 1'b0;
        probe_ctrl(1'b0, 1'b1, 1'b1);
        probe_dbg(3'd6, 32'd6, 8'h00);
        step();

        // basic issue and rename
        offer(3'd3, 3'd1, 3'd2); alloc_tag = 8'h21;
        expect_iss(8'h00, 32'd1, 8'h00, 32'd2);
        step(); inst_valid = 1'b0;
        step();
        probe_dbg(3'd3, 32'd3, 8'h21);

        // dependent source, then CDB resolve
        offer(3'd4, 3'd3, 3'd2); alloc_tag = 8'h22;
        expect_iss(8'h21, 32'd0, 8'h00, 32'd2);
        step(); inst_valid = 1'b0;
        step();
        cdb = {1'b1, 8'h21, 32'd7};
        step(); cdb = 41'h0;
        probe_dbg(3'd3, 32'd7, 8'h00);
        offer(3'd0, 3'd3, 3'd0);
        expect_iss(8'h00, 32'd7, 8'h00, 32'd0);
        step(); inst_valid = 1'b0;
        step();
        probe_dbg(3'd0, 32'd0, 8'h00);
        probe_dbg(3'd4, 32'd4, 8'h22);

        // same-cycle CDB bypass
        offer(3'd5, 3'd4, 3'd1); alloc_tag = 8'h23;
        expect_iss(8'h00, 32'd9, 8'h00, 32'd1);
        step(); inst_valid = 1'b0;
        cdb = {1'b1, 8'h22, 32'd9};
        step(); cdb = 41'h0;
        probe_dbg(3'd4, 32'd9, 8'h00);
        probe_dbg(3'd5, 32'd5, 8'h23);

        // rename and CDB capture on the same register, same edge
        offer(3'd5, 3'd5, 3'd0); alloc_tag = 8'h24;
        expect_iss(8'h00, 32'd11, 8'h00, 32'd0);
        step(); inst_valid = 1'b0;
        cdb = {1'b1, 8'h23, 32'd11};
        step(); cdb = 41'h0;
        probe_dbg(3'd5, 32'd11, 8'h24);

        // fill while busy, 5th refused, then drain with pointer wrap
        all_busy = 1'b1;
        expect_iss(8'h00, 32'd1, 8'h00, 32'd2);
        expect_iss(8'h00, 32'd7, 8'h00, 32'd9);
        expect_iss(8'h00, 32'd6, 8'h24, 32'd0);
        expect_iss(8'h31, 32'd0, 8'h00, 32'd7);
        for (int k = 0; k < 5; k++) begin
            offer(fill_rd[k], fill_rs1[k], fill_rs2[k]);
            step();
            if (k == 3) probe_ctrl(1'b0, 1'b0, 1'b0);
        end
        inst_valid = 1'b0;
        probe_ctrl(1'b0, 1'b0, 1'b0);
        step();
        all_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            alloc_tag = 8'h31 + 8'(k);
            step();
        end
        probe_ctrl(1'b0, 1'b1, 1'b1);
        probe_dbg(3'd1, 32'd1, 8'h31);
        probe_dbg(3'd6, 32'd6, 8'h34);
        probe_sb();
        step();
        probe_dbg(3'd3, 32'd7, 8'h33);
        probe_dbg(3'd7, 32'd7, 8'h00);
        step();

        // unmatched and zero CDB tags change nothing
        cdb = {1'b1, 8'h77, 32'd55};
        step();
        cdb = {1'b1, 8'h00, 32'd55};
        step(); cdb = 41'h0;
        probe_dbg(3'd2, 32'd2, 8'h32);
        probe_dbg(3'd0, 32'd0, 8'h00);
        step();

        // reset mid-operation
        all_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            offer(3'd7, 3'd1, 3'd2);
            step();
        end
        inst_valid = 1'b0;
        probe_ctrl(1'b0, 1'b1, 1'b0);
        step();
        rst = 1'b1;
        cdb = {1'b1, 8'h31, 32'd99};
        step(); cdb = 41'h0;
        probe_ctrl(1'b0, 1'b1, 1'b1);
        probe_dbg(3'd6, 32'd6, 8'h00);
        probe_dbg(3'd1, 32'd1, 8'h00);
        probe_dbg(3'd5, 32'd5, 8'h00);
        step();
        rst = 1'b0; all_busy = 1'b0;
        step(); step();
        probe_ctrl(1'b0, 1'b1, 1'b1);
        probe_sb();
        step(); step();

        if (probe_q.size() != 0) begin
            $display("FAIL probe_drain got %0d pending want 0", probe_q.size());
            $fatal(1, "probe queue not drained");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
